// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request FIFO feeding a 3-phase ALU issue FSM (IDLE/DRIVE/HOLD)
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_a,
  input  logic [7:0]             req_b,
  input  logic [3:0]             req_cmd,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_cmd,
  output logic                   alu_oe,
  input  logic [15:0]            alu_d,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [3:0]             rsp_cmd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t        state;
  logic [7:0]    mem_a   [DEPTH];
  logic [7:0]    mem_b   [DEPTH];
  logic [3:0]    mem_cmd [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign req_ready = (fifo_count < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_a[wr_ptr]   <= req_a;
      mem_b[wr_ptr]   <= req_b;
      mem_cmd[wr_ptr] <= req_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cmd    <= '0;
      alu_oe     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_cmd    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);

      case (state)
        IDLE: begin
          if (pop) begin
            alu_a   <= mem_a[rd_ptr];
            alu_b   <= mem_b[rd_ptr];
            alu_cmd <= mem_cmd[rd_ptr];
            alu_oe  <= 1'b1;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          // The ALU result is only trusted at the end of the single enabled cycle.
          rsp_data  <= alu_d;
          rsp_cmd   <= alu_cmd;
          rsp_valid <= 1'b1;
          alu_oe    <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - table-driven and sequence checks for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = '0;
  logic [7:0]  req_b = '0;
  logic [3:0]  req_cmd = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_d;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_cmd;
  logic [2:0]  fifo_count;
  logic        busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe), .alu_d(alu_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cmd(rsp_cmd),
    .fifo_count(fifo_count), .busy(busy)
  );

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = {8'h00, a};
    eb = {8'h00, b};
    case (c)
      4'd0:  return ea + eb;
      4'd1:  return ea - eb;
      4'd2:  return ea * eb;
      4'd3:  return ea & eb;
      4'd4:  return ea | eb;
      4'd5:  return ea ^ eb;
      4'd6:  return {a, b};
      4'd7:  return {b, a};
      4'd8:  return ea << 1;
      4'd9:  return eb << 4;
      4'd10: return ea >> 1;
      4'd11: return ea + eb + 16'd1;
      4'd12: return eb - ea;
      4'd13: return ~{a, b};
      4'd14: return ea;
      default: return {b, b};
    endcase
  endfunction

  // Junk outside the enabled cycle exposes any sampling of alu_d at the wrong time.
  assign alu_d = alu_oe ? alu_model(alu_a, alu_b, alu_cmd) : 16'hdead;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  cmd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [16];
  logic [15:0] exp_tab [16] = '{16'h003C, 16'h0028, 16'h01F4, 16'h0002, 16'h003A, 16'h0038,
                                16'h320A, 16'h0A32, 16'h0064, 16'h00A0, 16'h0019, 16'h003D,
                                16'hFFD8, 16'hCDF5, 16'h0032, 16'h0A0A};
  int exp_q [$];
  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_entry(input int idx);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_a = tbl[idx].a;
    req_b = tbl[idx].b;
    req_cmd = tbl[idx].cmd;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("push_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(idx);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_all_rsp", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int idx;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          idx = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(tbl[idx].exp));
          check("rsp_cmd", 32'(rsp_cmd), 32'(tbl[idx].cmd));
        end
      end
    end
  end

  initial begin
    int vcount;
    logic [15:0] held_data;
    for (int i = 0; i < 16; i++) tbl[i] = '{8'd50, 8'd10, 4'(i), exp_tab[i]};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_outputs", {alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, 2'b00}, 32'd0);
    check("rst_rsp", {rsp_data, rsp_cmd, 12'h000}, 32'd0);

    // single op latency
    rsp_ready = 1'b1;
    push_entry(0);
    @(negedge clk);
    req_valid = 1'b0;
    check("s1_count", 32'(fifo_count), 32'd1);
    check("s1_oe_low", 32'(alu_oe), 32'd0);
    @(negedge clk);
    check("s1_oe_high", 32'(alu_oe), 32'd1);
    check("s1_alu_ops", {16'h0, alu_a, alu_b}, {16'h0, 8'd50, 8'd10});
    check("s1_count_pop", 32'(fifo_count), 32'd0);
    check("s1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("s1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("s1_rsp_data", 32'(rsp_data), 32'd60);
    check("s1_rsp_cmd", 32'(rsp_cmd), 32'd0);
    check("s1_oe_done", 32'(alu_oe), 32'd0);
    @(negedge clk);
    check("s1_rsp_clear", 32'(rsp_valid), 32'd0);
    check("s1_idle", 32'(busy), 32'd0);
    check("s1_alu_hold", 32'(alu_a), 32'd50);

    // command sweep, pointers wrap four times
    for (int i = 0; i < 16; i++) push_entry(i);
    drain();

    // fill with backpressure, sixth request stalls
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_entry(i);
    @(negedge clk);
    req_valid = 1'b1;
    req_a = tbl[5].a; req_b = tbl[5].b; req_cmd = tbl[5].cmd;
    check("fill_count", 32'(fifo_count), 32'd4);
    check("fill_ready_low", 32'(req_ready), 32'd0);
    check("fill_rsp_valid", 32'(rsp_valid), 32'd1);
    held_data = rsp_data;
    check("fill_rsp_data", 32'(held_data), 32'(tbl[0].exp));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_data_stable", 32'(rsp_data), 32'(held_data));
      check("bp_cmd_stable", 32'(rsp_cmd), 32'(tbl[0].cmd));
      check("bp_no_pop", {28'h0, alu_oe, fifo_count}, {28'h0, 1'b0, 3'd4});
      check("bp_stall", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rsp", 32'(rsp_valid), 32'd0);
    check("bp_release_still_full", {28'h0, req_ready, fifo_count}, {28'h0, 1'b0, 3'd4});
    @(negedge clk);
    check("bp_next_pop_oe", 32'(alu_oe), 32'd1);
    check("bp_next_pop_cmd", 32'(alu_cmd), 32'(tbl[1].cmd));
    check("bp_next_pop_count", 32'(fifo_count), 32'd3);
    check("bp_ready_again", 32'(req_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(5);
    @(negedge clk);
    req_valid = 1'b0;
    check("stall_accepted", 32'(fifo_count), 32'd4);
    drain();

    // simultaneous push and pop at count 2
    rsp_ready = 1'b0;
    for (int i = 1; i < 4; i++) push_entry(i);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("pp_pre_count", 32'(fifo_count), 32'd2);
    @(negedge clk);
    req_valid = 1'b1;
    req_a = tbl[4].a; req_b = tbl[4].b; req_cmd = tbl[4].cmd;
    check("pp_idle_count", 32'(fifo_count), 32'd2);
    @(posedge clk);
    exp_q.push_back(4);
    @(negedge clk);
    req_valid = 1'b0;
    check("pp_count_same", 32'(fifo_count), 32'd2);
    check("pp_pop_head", {27'h0, alu_oe, alu_cmd}, {27'h0, 1'b1, tbl[2].cmd});
    drain();

    // reset mid-DRIVE with three entries queued
    rsp_ready = 1'b0;
    for (int i = 5; i < 10; i++) push_entry(i);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rd_pre_drive", {28'h0, alu_oe, fifo_count}, {28'h0, 1'b1, 3'd3});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("rd_count", 32'(fifo_count), 32'd0);
    check("rd_outputs", {alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, 2'b00}, 32'd0);
    check("rd_rsp", {rsp_data, rsp_cmd, 12'h000}, 32'd0);
    check("rd_ready_busy", {30'h0, req_ready, busy}, {30'h0, 1'b1, 1'b0});
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid || alu_oe) vcount++;
    end
    check("rd_no_discarded_rsp", 32'(vcount), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries (power of two).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req_valid  input  1  request presented.
REQ-005 req_ready  output  1  request accepted when high with req_valid.
REQ-006 req_a  input  8  operand A.
REQ-007 req_b  input  8  operand B.
REQ-008 req_cmd  input  4  ALU command code.
REQ-009 alu_a  output  8  operand A driven to ALU a_in.
REQ-010 alu_b  output  8  operand B driven to ALU b_in.
REQ-011 alu_cmd  output  4  command driven to ALU command_in.
REQ-012 alu_oe  output  1  ALU output enable.
REQ-013 alu_d  input  16  ALU d_out.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_data  output  16  captured ALU result.
REQ-017 rsp_cmd  output  4  command that produced rsp_data.
REQ-018 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 busy  output  1  high when FSM not IDLE or fifo_count nonzero.

Function
REQ-020 FIFO SHALL store {a,b,cmd} entries, in-order, DEPTH deep, circular pointers wrapping DEPTH-1 -> 0.
REQ-021 req_ready SHALL equal (fifo_count < DEPTH), combinational from registered count; no bypass when full even if a pop occurs that cycle.
REQ-022 Push SHALL occur on edge where req_valid && req_ready; inputs captured that edge.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged and both operations take effect.
REQ-024 FSM states SHALL be IDLE, DRIVE, HOLD.
REQ-025 IDLE: if fifo_count > 0, pop head entry into alu_a/alu_b/alu_cmd registers, set alu_oe=1, go DRIVE; else stay IDLE.
REQ-026 DRIVE: lasts exactly one cycle; at its closing edge rsp_data <= alu_d, rsp_cmd <= alu_cmd, rsp_valid <= 1, alu_oe <= 0, go HOLD.
REQ-027 HOLD: rsp_data/rsp_cmd/rsp_valid SHALL remain stable; on edge with rsp_ready=1, rsp_valid <= 0, go IDLE; no pop in HOLD.
REQ-028 Latency: push at edge E into empty FIFO with FSM IDLE -> pop at E+1, rsp_valid high after E+2.
REQ-029 Peak throughput SHALL be one result per 3 cycles when rsp_ready held high.
REQ-030 alu_a/alu_b/alu_cmd SHALL hold last popped values outside DRIVE; alu_oe high only in DRIVE.
REQ-031 Push while full SHALL be impossible (req_ready low); req_valid held SHALL be accepted in the first cycle count < DEPTH.
REQ-032 alu_d SHALL be sampled only at the closing DRIVE edge; values in other cycles ignored.

Reset
REQ-033 With rst_n=0 at an edge: FSM -> IDLE, FIFO pointers and fifo_count -> 0, alu_a/alu_b/alu_cmd -> 0, alu_oe -> 0, rsp_valid -> 0, rsp_data -> 0, rsp_cmd -> 0.
REQ-034 Reset SHALL take priority over push, pop and state transition in the same cycle, including mid-DRIVE or mid-HOLD; pending entries discarded.
REQ-035 After reset release req_ready SHALL be 1 and busy 0.

Verification
REQ-036 Single op: push a=50,b=10,cmd=0, ALU model d=a+b, rsp_ready=1 -> alu_oe high one cycle, rsp_valid after 2 edges, rsp_data=60, rsp_cmd=0.
REQ-037 Fill: push 5 back-to-back with rsp_ready=0 -> first pops, next 4 fill FIFO, fifo_count=4, req_ready=0, 6th request stalls until first result consumed.
REQ-038 Backpressure: result in HOLD, rsp_ready=0 for 5 cycles -> rsp_data/rsp_cmd stable, no pop, alu_oe=0; rsp_ready=1 -> next pop following cycle.
REQ-039 Command sweep: push cmd 0..15 with a=50,b=10 -> 16 responses in order, rsp_cmd 0..15, each rsp_data equals model output; pointers wrap 4 times.
REQ-040 Reset mid-DRIVE with 3 queued entries -> next edge all outputs zero, fifo_count=0, no response ever emitted for discarded entries.
REQ-041 Simultaneous push/pop at fifo_count=2 -> fifo_count stays 2, order preserved.
